// File: rtl/perip_arbiter.sv
// perip_arbiter: two-master round-robin arbiter in front of the peripheral
// decoder's single data port. Every downstream signal is registered. Read
// data is captured RD_LAT cycles after the address is driven.
// Optional macro PERIP_ARB_LOCK_EN adds m0_lock/m1_lock, which let a master
// keep ownership across back-to-back transactions (atomic read-modify-write).
module perip_arbiter #(
   parameter int                DATA_W    = 32,
   parameter int                RD_LAT    = 1,
   parameter logic [DATA_W-1:0] PARK_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_rw,
   input  logic [DATA_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_ack,
   input  logic              m1_req,
   input  logic              m1_rw,
   input  logic [DATA_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_ack,
`ifdef PERIP_ARB_LOCK_EN
   input  logic              m0_lock,
   input  logic              m1_lock,
`endif
   output logic [DATA_W-1:0] rdata,
   output logic              mem_rw,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        grant,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state_q, state_d;
   logic              mem_rw_q, mem_rw_d;
   logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [1:0]        grant_q, grant_d;
   logic [1:0]        ack_q, ack_d;
   logic              last_q, last_d;   // 1 = m1 was served last
   logic              win_q, win_d;     // owner of the current transaction
   logic [2:0]        cnt_q, cnt_d;
`ifdef PERIP_ARB_LOCK_EN
   logic              lock_q, lock_d;
   logic              lock_own_q, lock_own_d;
`endif

   logic              ok0, ok1, pick, sel_rw;
   logic [DATA_W-1:0] sel_addr, sel_wdata;

   // Next-state and registered-output logic of the arbitration FSM
   always_comb begin
      state_d     = state_q;
      mem_rw_d    = mem_rw_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;
      grant_d     = grant_q;
      ack_d       = 2'b00;
      last_d      = last_q;
      win_d       = win_q;
      cnt_d       = cnt_q;
`ifdef PERIP_ARB_LOCK_EN
      lock_d      = lock_q;
      lock_own_d  = lock_own_q;
`endif
      ok0 = m0_req;
      ok1 = m1_req;
`ifdef PERIP_ARB_LOCK_EN
      // While locked, only the lock owner may be granted
      if (lock_q) begin
         ok0 = m0_req & ~lock_own_q;
         ok1 = m1_req &  lock_own_q;
      end
`endif
      // On a tie the master that was not served last wins
      pick      = (ok0 && ok1) ? ~last_q : ok1;
      sel_rw    = pick ? m1_rw    : m0_rw;
      sel_addr  = pick ? m1_addr  : m0_addr;
      sel_wdata = pick ? m1_wdata : m0_wdata;

      case (state_q)
         IDLE: begin
            if (ok0 || ok1) begin
               state_d     = BUSY;
               win_d       = pick;
               grant_d     = pick ? 2'b10 : 2'b01;
               mem_rw_d    = sel_rw;
               mem_addr_d  = sel_addr;
               mem_wdata_d = sel_rw ? sel_wdata : '0;
               cnt_d       = sel_rw ? 3'd0 : 3'(RD_LAT);
`ifdef PERIP_ARB_LOCK_EN
               if (!lock_q) last_d = pick;
`else
               last_d      = pick;
`endif
            end
         end
         BUSY: begin
            if (cnt_q == 3'd0) begin
               state_d     = DONE;
               if (!mem_rw_q) rdata_d = mem_rdata;
               mem_rw_d    = 1'b0;
               mem_addr_d  = PARK_ADDR;
               mem_wdata_d = '0;
               grant_d     = 2'b00;
               ack_d       = win_q ? 2'b10 : 2'b01;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         DONE: begin
            state_d = IDLE;
`ifdef PERIP_ARB_LOCK_EN
            lock_d     = win_q ? m1_lock : m0_lock;
            lock_own_d = win_q;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         mem_rw_q    <= 1'b0;
         mem_addr_q  <= PARK_ADDR;
         mem_wdata_q <= '0;
         rdata_q     <= '0;
         grant_q     <= 2'b00;
         ack_q       <= 2'b00;
         last_q      <= 1'b1;
         win_q       <= 1'b0;
         cnt_q       <= 3'd0;
`ifdef PERIP_ARB_LOCK_EN
         lock_q      <= 1'b0;
         lock_own_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         mem_rw_q    <= mem_rw_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
         grant_q     <= grant_d;
         ack_q       <= ack_d;
         last_q      <= last_d;
         win_q       <= win_d;
         cnt_q       <= cnt_d;
`ifdef PERIP_ARB_LOCK_EN
         lock_q      <= lock_d;
         lock_own_q  <= lock_own_d;
`endif
      end
   end

   assign m0_ack    = ack_q[0];
   assign m1_ack    = ack_q[1];
   assign rdata     = rdata_q;
   assign mem_rw    = mem_rw_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign grant     = grant_q;
   assign busy      = (state_q != IDLE);

endmodule
